// File: rtl/i2s_sample_sink.sv
// i2s_sample_sink: buffers offset-binary samples and plays them, mono on both channels, to an I2S DAC.
// Latency: a sample waiting in the FIFO is popped at the next frame start; its MSB leaves in slot 1.
// Backpressure: sample_ready is registered !full; SINK_UNDERRUN_HOLD_EN repeats the last word on underrun.

module sink_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 8,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_active_high,
   input  logic          push,
   input  logic [W-1:0]  push_dat,
   input  logic          pop,
   output logic [W-1:0]  pop_dat,
   output logic          empty,
   output logic          full_nxt,
   output logic [LW-1:0] level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop;

   always_comb begin
      do_push  = push && (level_q != LW'(DEPTH));
      do_pop   = pop && (level_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_active_high) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat;
   end

   assign pop_dat  = mem_q[rd_ptr_q];
   assign empty    = (level_q == '0);
   assign full_nxt = (level_d == LW'(DEPTH));
   assign level    = level_q;
endmodule

module i2s_sample_sink #(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_active_high,
   input  logic [15:0]                   sample_in,
   input  logic                          sample_valid,
   output logic                          sample_ready,
   input  logic                          underrun_clr,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          i2s_bclk,
   output logic                          i2s_lrclk,
   output logic                          i2s_sdata
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int DW = $clog2(CLK_DIV);

   logic [DW-1:0] div_q, div_d;
   logic          bclk_q, bclk_d;
   logic          lrclk_q, lrclk_d;
   logic          sdata_q, sdata_d;
   logic [4:0]    slot_q, slot_d;
   logic [15:0]   cur_word_q, cur_word_d;
   logic [15:0]   next_word_q, next_word_d;
   logic          underrun_q, underrun_d;
   logic          ready_q, ready_d;
   logic          fall;
   logic [3:0]    bit_idx;
   logic          fifo_push, fifo_pop, fifo_empty, fifo_full_nxt;
   logic [15:0]   fifo_dat;
   logic [LW-1:0] fifo_lvl;
`ifdef SINK_UNDERRUN_HOLD_EN
   logic [15:0]   last_word_q, last_word_d;
`endif

   assign fifo_push = sample_valid && ready_q;

   sink_fifo #(
      .W     (16),
      .DEPTH (FIFO_DEPTH),
      .LW    (LW)
   ) u_fifo (
      .clk             (clk),
      .rst_active_high (rst_active_high),
      .push            (fifo_push),
      .push_dat        (sample_in ^ 16'h8000),
      .pop             (fifo_pop),
      .pop_dat         (fifo_dat),
      .empty           (fifo_empty),
      .full_nxt        (fifo_full_nxt),
      .level           (fifo_lvl)
   );

   always_comb begin
      div_d  = div_q + DW'(1);
      bclk_d = bclk_q;
      fall   = 1'b0;
      if (div_q == DW'(CLK_DIV - 1)) begin
         div_d  = '0;
         bclk_d = ~bclk_q;
         fall   = bclk_q;
      end
   end

   // Bit for the slot being entered is cur_word[15 - slot_q[3:0]], i.e. one bclk behind lrclk.
   assign bit_idx = ~slot_q[3:0];

   always_comb begin
      slot_d      = slot_q;
      lrclk_d     = lrclk_q;
      sdata_d     = sdata_q;
      cur_word_d  = cur_word_q;
      next_word_d = next_word_q;
      underrun_d  = underrun_q && !underrun_clr;
      fifo_pop    = 1'b0;
`ifdef SINK_UNDERRUN_HOLD_EN
      last_word_d = last_word_q;
`endif
      if (fall) begin
         slot_d  = slot_q + 5'd1;
         lrclk_d = slot_d[4];
         if (slot_q == 5'd31) begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               next_word_d = fifo_dat;
`ifdef SINK_UNDERRUN_HOLD_EN
               last_word_d = fifo_dat;
`endif
            end else begin
               underrun_d  = 1'b1;
`ifdef SINK_UNDERRUN_HOLD_EN
               next_word_d = last_word_q;
`else
               next_word_d = 16'h0000;
`endif
            end
         end
         if (slot_q == 5'd0) begin
            cur_word_d = next_word_q;
            sdata_d    = next_word_q[15];
         end else begin
            sdata_d    = cur_word_q[bit_idx];
         end
      end
   end

   assign ready_d = !fifo_full_nxt;

   always_ff @(posedge clk) begin
      if (rst_active_high) begin
         div_q       <= '0;
         bclk_q      <= 1'b0;
         lrclk_q     <= 1'b0;
         sdata_q     <= 1'b0;
         slot_q      <= '0;
         cur_word_q  <= 16'h0000;
         next_word_q <= 16'h0000;
         underrun_q  <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         div_q       <= div_d;
         bclk_q      <= bclk_d;
         lrclk_q     <= lrclk_d;
         sdata_q     <= sdata_d;
         slot_q      <= slot_d;
         cur_word_q  <= cur_word_d;
         next_word_q <= next_word_d;
         underrun_q  <= underrun_d;
         ready_q     <= ready_d;
      end
   end

`ifdef SINK_UNDERRUN_HOLD_EN
   always_ff @(posedge clk) begin
      if (rst_active_high) last_word_q <= 16'h0000;
      else                 last_word_q <= last_word_d;
   end
`endif

   assign sample_ready = ready_q;
   assign underrun     = underrun_q;
   assign fifo_level   = fifo_lvl;
   assign i2s_bclk     = bclk_q;
   assign i2s_lrclk    = lrclk_q;
   assign i2s_sdata    = sdata_q;
endmodule
